reg_serial_tx: RTL

Parallel-in, serial-out transmitter for the 8-bit computer's output port. It accepts one byte through a valid/ready handshake and holds it in an internal shift register. It then drives the byte onto a single line as an asynchronous frame: start bit, 8 data bits LSB first, stop bit. It is the outbound counterpart of the parallel-load registers: a register value is loaded in parallel and read out one bit at a time.

---
 rtl/reg_serial_tx.sv | 113 +++++++++++
 1 files changed

// File: rtl/reg_serial_tx.sv
// reg_serial_tx: byte-wide parallel-load register that shifts out as an
// asynchronous serial frame (start, 8 data bits LSB first, stop).
module reg_serial_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       tx_done
);

  // Divider must hold CLKS_PER_BIT-1; keep at least one bit when N=1.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] div_q, div_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_out_q, tx_out_d;
  logic          tx_done_q, tx_done_d;
  logic          div_term;

  assign div_term = (div_q == DIV_LAST);

  // Next-state: accept in IDLE, otherwise step the bit timer and advance
  // the frame on terminal count. tx_out_d is the line level for the next
  // state so the serial output stays a clean register.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    tx_out_d  = tx_out_q;
    tx_done_d = 1'b0;
    case (state_q)
      S_START: begin
        div_d = div_term ? '0 : div_q + 1'b1;
        if (div_term) begin
          state_d  = S_DATA;
          idx_d    = 3'd0;
          tx_out_d = shift_q[0];
        end
      end
      S_DATA: begin
        div_d = div_term ? '0 : div_q + 1'b1;
        if (div_term) begin
          // Exit on index 7 explicitly rather than relying on the 3-bit wrap.
          if (idx_q == 3'd7) begin
            state_d  = S_STOP;
            tx_out_d = 1'b1;
          end else begin
            shift_d  = shift_q >> 1;
            idx_d    = idx_q + 3'd1;
            tx_out_d = shift_q[1];
          end
        end
      end
      S_STOP: begin
        div_d = div_term ? '0 : div_q + 1'b1;
        if (div_term) begin
          state_d   = S_IDLE;
          tx_done_d = 1'b1;
          tx_out_d  = 1'b1;
        end
      end
      default: begin
        tx_out_d = 1'b1;
        if (tx_valid) begin
          state_d  = S_START;
          shift_d  = tx_data;
          div_d    = '0;
          idx_d    = 3'd0;
          tx_out_d = 1'b0;
        end
      end
    endcase
  end

  // State registers; reset abandons any frame and forces the line high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      tx_out_q  <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      tx_out_q  <= tx_out_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign tx_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign tx_out   = tx_out_q;
  assign tx_done  = tx_done_q;

endmodule
